// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: data word, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single RAM port between icache and dcache: one latched request per
// transaction, dcache preferred unless it has starved a pending icache fetch.
//
// state | meaning
// IDLE  | no transaction; next requester chosen on the coming edge
// IGNT  | icache request latched and driven to RAM until ACCESS/ERROR
// DGNT  | dcache request latched and driven to RAM until ACCESS/ERROR
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [ADDR_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [ADDR_W-1:0] dstore,
  output logic              dwait,
  output logic [ADDR_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [ADDR_W-1:0] ramstore,
  input  logic [ADDR_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              arb_err
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_IGNT = IGNT;
  localparam logic [1:0] S_DGNT = DGNT;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_store;
  logic              r_wr;
  logic [CNT_W-1:0]  r_starve_cnt;

  logic w_dreq;
  logic w_take_d;
  logic w_take_i;
  logic w_access;
  logic w_error;

  assign w_dreq   = dREN | dWEN;
  assign w_access = (ramstate == ACCESS);
  assign w_error  = (ramstate == ERROR);

  // A saturated counter only yields to the icache while it is actually asking.
  always_comb begin
    w_take_d = 1'b0;
    w_take_i = 1'b0;
    if (w_dreq && (r_starve_cnt < STARVE_LIM)) begin
      w_take_d = 1'b1;
    end else if (iREN) begin
      w_take_i = 1'b1;
    end else if (w_dreq) begin
      w_take_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_store      <= '0;
      r_wr         <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take_d) begin
            r_state <= S_DGNT;
            r_addr  <= daddr;
            r_store <= dstore;
            r_wr    <= dWEN;
          end else if (w_take_i) begin
            r_state <= S_IGNT;
            r_addr  <= iaddr;
            r_store <= '0;
            r_wr    <= 1'b0;
          end
        end
        S_IGNT: begin
          if (w_access) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= '0;
          end else if (w_error) begin
            r_state <= S_IDLE;
          end
        end
        S_DGNT: begin
          if (w_access) begin
            r_state <= S_IDLE;
            if (!iREN) begin
              r_starve_cnt <= '0;
            end else if (r_starve_cnt < STARVE_LIM) begin
              r_starve_cnt <= r_starve_cnt + 1'b1;
            end
          end else if (w_error) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode from state so an async reset drops them without a clock edge.
  assign ramREN   = (r_state == S_IGNT) || ((r_state == S_DGNT) && !r_wr);
  assign ramWEN   = (r_state == S_DGNT) && r_wr;
  assign ramaddr  = r_addr;
  assign ramstore = r_store;

  assign iwait   = !((r_state == S_IGNT) && w_access);
  assign dwait   = !((r_state == S_DGNT) && w_access);
  assign iload   = ramload;
  assign dload   = ramload;
  assign arb_err = (r_state != S_IDLE) && w_error;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: per-cycle vector table plus starvation and reset sequences.
module tb_cache_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, arb_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_checks = 0;
  int n_errors = 0;

  cache_mem_arbiter #(.STARVE_MAX(4), .ADDR_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        iren;
    logic [31:0] ia;
    logic        dren;
    logic        dwen;
    logic [31:0] da;
    logic [31:0] ds;
    logic [1:0]  rs;
    logic [31:0] rl;
    logic        e_iw;
    logic        e_dw;
    logic        e_rr;
    logic        e_rw;
    logic [31:0] e_ra;
    logic [31:0] e_st;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string nm, input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic [31:0] da,
                     input logic [31:0] ds, input logic [1:0] rs, input logic [31:0] rl,
                     input logic eiw, input logic edw, input logic err_r, input logic erw,
                     input logic [31:0] era, input logic [31:0] est, input logic eer);
    vec_t v;
    v.name = nm; v.iren = ir; v.ia = ia; v.dren = dr; v.dwen = dw; v.da = da; v.ds = ds;
    v.rs = rs; v.rl = rl; v.e_iw = eiw; v.e_dw = edw; v.e_rr = err_r; v.e_rw = erw;
    v.e_ra = era; v.e_st = est; v.e_err = eer;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
  endtask

  initial begin
    string seq;
    int    nd;
    int    cyc;
    logic  chk4;

    nRST = 1'b0; iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    drive_idle();

    //  name        iREN ia        dR dW da        ds          rs      rl            iw dw rR rW ra        st          err
    add("t1_req",   1, 32'h40,   0, 0, 32'h0,   32'h0,      FREE,   32'h0,        1, 1, 0, 0, 32'h0,   32'h0,      0);
    add("t1_busy1", 1, 32'h40,   0, 0, 32'h0,   32'h0,      BUSY,   32'h0,        1, 1, 1, 0, 32'h40,  32'h0,      0);
    add("t1_busy2", 1, 32'h40,   0, 0, 32'h0,   32'h0,      BUSY,   32'h0,        1, 1, 1, 0, 32'h40,  32'h0,      0);
    add("t1_acc",   0, 32'h40,   0, 0, 32'h0,   32'h0,      ACCESS, 32'h11112222, 0, 1, 1, 0, 32'h40,  32'h0,      0);
    add("t1_idle",  0, 32'h40,   0, 0, 32'h0,   32'h0,      FREE,   32'h0,        1, 1, 0, 0, 32'h40,  32'h0,      0);
    add("t2_req",   1, 32'h44,   0, 1, 32'h80,  32'hDEADBEEF, FREE, 32'h0,        1, 1, 0, 0, 32'h40,  32'h0,      0);
    add("t2_busy",  1, 32'h44,   0, 1, 32'h80,  32'hDEADBEEF, BUSY, 32'h0,        1, 1, 0, 1, 32'h80,  32'hDEADBEEF, 0);
    add("t2_acc",   1, 32'h44,   0, 0, 32'h80,  32'hDEADBEEF, ACCESS, 32'h0,      1, 0, 0, 1, 32'h80,  32'hDEADBEEF, 0);
    add("t2_idle",  1, 32'h44,   0, 0, 32'h80,  32'hDEADBEEF, FREE, 32'h0,        1, 1, 0, 0, 32'h80,  32'hDEADBEEF, 0);
    add("t2_igrant",0, 32'h44,   0, 0, 32'h80,  32'h0,      ACCESS, 32'hCAFE0001, 0, 1, 1, 0, 32'h44,  32'h0,      0);
    add("t2_done",  0, 32'h44,   0, 0, 32'h80,  32'h0,      FREE,   32'h0,        1, 1, 0, 0, 32'h44,  32'h0,      0);
    add("t4_req",   0, 32'h0,    1, 0, 32'h80,  32'h0,      FREE,   32'h0,        1, 1, 0, 0, 32'h44,  32'h0,      0);
    add("t4_chg1",  0, 32'h0,    1, 0, 32'h84,  32'h0,      BUSY,   32'h0,        1, 1, 1, 0, 32'h80,  32'h0,      0);
    add("t4_chg2",  0, 32'h0,    1, 0, 32'h84,  32'h0,      BUSY,   32'h0,        1, 1, 1, 0, 32'h80,  32'h0,      0);
    add("t4_acc",   0, 32'h0,    1, 0, 32'h84,  32'h0,      ACCESS, 32'h0BADF00D, 1, 0, 1, 0, 32'h80,  32'h0,      0);
    add("t4_idle",  0, 32'h0,    1, 0, 32'h84,  32'h0,      FREE,   32'h0,        1, 1, 0, 0, 32'h80,  32'h0,      0);
    add("t4_next",  0, 32'h0,    0, 0, 32'h84,  32'h0,      ACCESS, 32'h00000084, 1, 0, 1, 0, 32'h84,  32'h0,      0);
    add("t4_done",  0, 32'h0,    0, 0, 32'h84,  32'h0,      FREE,   32'h0,        1, 1, 0, 0, 32'h84,  32'h0,      0);
    add("t5_req",   1, 32'h100,  0, 0, 32'h0,   32'h0,      FREE,   32'h0,        1, 1, 0, 0, 32'h84,  32'h0,      0);
    add("t5_err",   1, 32'h100,  0, 0, 32'h0,   32'h0,      ERROR,  32'h0,        1, 1, 1, 0, 32'h100, 32'h0,      1);
    add("t5_idle",  1, 32'h100,  0, 0, 32'h0,   32'h0,      FREE,   32'h0,        1, 1, 0, 0, 32'h100, 32'h0,      0);
    add("t5_retry", 0, 32'h100,  0, 0, 32'h0,   32'h0,      ACCESS, 32'h12345678, 0, 1, 1, 0, 32'h100, 32'h0,      0);
    add("t5_done",  0, 32'h100,  0, 0, 32'h0,   32'h0,      FREE,   32'h0,        1, 1, 0, 0, 32'h100, 32'h0,      0);
    add("rw_req",   0, 32'h0,    1, 1, 32'h200, 32'h55,     FREE,   32'h0,        1, 1, 0, 0, 32'h100, 32'h0,      0);
    add("rw_busy",  0, 32'h0,    1, 1, 32'h200, 32'h55,     BUSY,   32'h0,        1, 1, 0, 1, 32'h200, 32'h55,     0);
    add("rw_acc",   0, 32'h0,    0, 0, 32'h200, 32'h55,     ACCESS, 32'h0,        1, 0, 0, 1, 32'h200, 32'h55,     0);
    add("rw_idle",  0, 32'h0,    0, 0, 32'h200, 32'h55,     FREE,   32'h0,        1, 1, 0, 0, 32'h200, 32'h55,     0);

    repeat (3) @(negedge CLK);
    #1;
    check("rst_iwait", {31'b0, iwait}, 32'd1);
    check("rst_dwait", {31'b0, dwait}, 32'd1);
    check("rst_strobes", {30'b0, ramREN, ramWEN}, 32'd0);
    check("rst_addr", ramaddr, 32'h0);
    check("rst_err", {31'b0, arb_err}, 32'd0);
    nRST = 1'b1;

    foreach (vq[k]) begin
      @(negedge CLK);
      iREN = vq[k].iren; iaddr = vq[k].ia; dREN = vq[k].dren; dWEN = vq[k].dwen;
      daddr = vq[k].da; dstore = vq[k].ds; ramstate = vq[k].rs; ramload = vq[k].rl;
      #1;
      check({vq[k].name, "_iwait"}, {31'b0, iwait}, {31'b0, vq[k].e_iw});
      check({vq[k].name, "_dwait"}, {31'b0, dwait}, {31'b0, vq[k].e_dw});
      check({vq[k].name, "_strobes"}, {30'b0, ramREN, ramWEN}, {30'b0, vq[k].e_rr, vq[k].e_rw});
      check({vq[k].name, "_ramaddr"}, ramaddr, vq[k].e_ra);
      check({vq[k].name, "_ramstore"}, ramstore, vq[k].e_st);
      check({vq[k].name, "_arb_err"}, {31'b0, arb_err}, {31'b0, vq[k].e_err});
      if (!vq[k].e_iw) check({vq[k].name, "_iload"}, iload, vq[k].rl);
      if (!vq[k].e_dw) check({vq[k].name, "_dload"}, dload, vq[k].rl);
    end

    // Starvation: dcache hammers while icache waits; RAM answers in the first grant cycle.
    seq = ""; nd = 0; cyc = 0; chk4 = 1'b0;
    while (nd < 5 && cyc < 80) begin
      @(negedge CLK);
      iREN = 1; iaddr = 32'h400; dREN = 1; dWEN = 0; daddr = 32'h300;
      ramstate = (ramREN || ramWEN) ? ACCESS : FREE;
      ramload = 32'hA000 + cyc;
      #1;
      if (chk4) begin
        check("t3_cnt_sat", 32'(dut.r_starve_cnt), 32'd4);
        chk4 = 1'b0;
      end
      check("t3_one_wait", {31'b0, (!iwait && !dwait)}, 32'd0);
      if (!dwait) begin seq = {seq, "D"}; nd++; if (nd == 4) chk4 = 1'b1; end
      if (!iwait) begin seq = {seq, "I"}; nd++; end
      cyc++;
    end
    if (nd < 5) begin
      n_checks++; n_errors++;
      $display("FAIL t3_timeout: got %0d completions expected 5", nd);
    end
    n_checks++;
    if (seq != "DDDDI") begin
      n_errors++;
      $display("FAIL t3_order: got %s expected DDDDI", seq);
    end
    @(negedge CLK);
    drive_idle();
    #1;
    check("t3_cnt_clear", 32'(dut.r_starve_cnt), 32'd0);

    // Asynchronous reset in the middle of a dcache write.
    @(negedge CLK);
    drive_idle();
    @(negedge CLK);
    dWEN = 1; daddr = 32'h500; dstore = 32'h77;
    @(negedge CLK);
    ramstate = BUSY;
    #1;
    check("t6_pre_wen", {31'b0, ramWEN}, 32'd1);
    #1 nRST = 1'b0;
    #1;
    check("t6_wen_drop", {31'b0, ramWEN}, 32'd0);
    check("t6_ren", {31'b0, ramREN}, 32'd0);
    check("t6_dwait", {31'b0, dwait}, 32'd1);
    check("t6_state", 32'(dut.r_state), 32'd0);
    check("t6_addr", ramaddr, 32'h0);
    @(negedge CLK);
    drive_idle();
    nRST = 1'b1;
    @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
